// File: rtl/card_shoe_pkg.sv
// Shared constants, state encoding and helper functions for the card shoe dealer.
package card_shoe_pkg;

  localparam int unsigned NUM_RANKS = 13;
  localparam int unsigned SUITS     = 4;
  localparam int unsigned RANK_W    = 4;
  localparam int unsigned CARD_W    = 8;
  localparam int unsigned VALUE_W   = 4;

  localparam logic [RANK_W-1:0] RANK_ACE   = 4'd1;
  localparam logic [RANK_W-1:0] RANK_TWO   = 4'd2;
  localparam logic [RANK_W-1:0] RANK_TEN   = 4'd10;
  localparam logic [RANK_W-1:0] RANK_JACK  = 4'd11;
  localparam logic [RANK_W-1:0] RANK_QUEEN = 4'd12;
  localparam logic [RANK_W-1:0] RANK_KING  = 4'd13;

  localparam int unsigned LFSR_W_MIN = 16;
  localparam int unsigned LFSR_W_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_PROBE = 2'd2
  } state_e;

  // Right-shift Galois feedback masks for maximal-length sequences, by width.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      25: return 32'h0120_0000;
      26: return 32'h0200_0023;
      27: return 32'h0400_0013;
      28: return 32'h0900_0000;
      29: return 32'h1400_0000;
      30: return 32'h2000_0029;
      31: return 32'h4800_0000;
      32: return 32'h8020_0003;
      default: return 32'h0000_D008;
    endcase
  endfunction

  // Fold a random nibble onto a rank 1..13; 0 and 14 land on ace, 15 on two.
  function automatic logic [RANK_W-1:0] cand_rank(input logic [3:0] nib);
    logic [RANK_W-1:0] r;
    r = nib;
    if (nib == 4'd0 || nib == 4'd14) r = RANK_ACE;
    else if (nib == 4'd15)           r = RANK_TWO;
    return r;
  endfunction

  // Next rank in probe order, king wraps to ace.
  function automatic logic [RANK_W-1:0] next_rank(input logic [RANK_W-1:0] r);
    return (r == RANK_KING) ? RANK_ACE : r + 4'd1;
  endfunction

  // Blackjack value: face cards count ten, ace reported as one.
  function automatic logic [VALUE_W-1:0] card_value(input logic [RANK_W-1:0] r);
    return (r > RANK_TEN) ? RANK_TEN : r;
  endfunction

endpackage

// File: rtl/card_shoe_lfsr.sv
// Free-running Galois LFSR used as the card selection entropy source.
module card_shoe_lfsr
  import card_shoe_pkg::*;
#(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  // Shift right and fold the feedback mask in when a one falls out.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
  end

  // State register; an all-zero seed would lock up, so it is bumped to one.
  always_ff @(posedge clk_i) begin
    if (!rst_i) lfsr_q <= SEED_EFF;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/card_shoe_dealer.sv
// Multi-deck card shoe: per-rank counters, random rank pick with linear probe.
module card_shoe_dealer
  import card_shoe_pkg::*;
#(
  parameter int unsigned       NUM_DECKS = 1,
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1)
) (
  input  logic                                                clk_i,
  input  logic                                                rst_i,
  input  logic                                                request_card_i,
  input  logic                                                shuffle_i,
  output logic [CARD_W-1:0]                                   card_to_send_o,
  output logic [VALUE_W-1:0]                                  card_value_o,
  output logic                                                card_valid_o,
  output logic                                                busy_o,
  output logic [$clog2(NUM_RANKS*SUITS*NUM_DECKS+1)-1:0]      remaining_o,
  output logic                                                empty_err_o
);

  localparam int unsigned CNT_W = $clog2(SUITS*NUM_DECKS+1);
  localparam int unsigned REM_W = $clog2(NUM_RANKS*SUITS*NUM_DECKS+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SUITS*NUM_DECKS);
  localparam logic [REM_W-1:0] FULL_REM = REM_W'(NUM_RANKS*SUITS*NUM_DECKS);

  state_e              state_q, state_d;
  logic [RANK_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    count_q [NUM_RANKS];
  logic [REM_W-1:0]    remaining_q, remaining_d;
  logic [CARD_W-1:0]   card_q, card_d;
  logic [VALUE_W-1:0]  value_q, value_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                refill_c, take_c, hit_c;
  logic [LFSR_W-1:0]   lfsr_q;
  logic                lfsr_unused_c;

  card_shoe_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .lfsr_o (lfsr_q)
  );

  // Only the low nibble picks a rank; the rest just keeps the sequence long.
  assign lfsr_unused_c = ^lfsr_q[LFSR_W-1:4];

  // Does the rank currently being probed still have cards left?
  always_comb begin
    hit_c = 1'b0;
    for (int unsigned r = 0; r < NUM_RANKS; r++) begin
      if (idx_q == RANK_W'(r + 1) && count_q[r] != '0) hit_c = 1'b1;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    card_d      = card_q;
    value_d     = value_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    refill_c    = 1'b0;
    take_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (shuffle_i) begin
          refill_c    = 1'b1;
          remaining_d = FULL_REM;
        end else if (request_card_i) begin
          if (remaining_q == '0) err_d   = 1'b1;
          else                   state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        idx_d   = cand_rank(lfsr_q[3:0]);
        state_d = ST_PROBE;
      end
      ST_PROBE: begin
        if (hit_c) begin
          take_c      = 1'b1;
          remaining_d = remaining_q - REM_W'(1);
          card_d      = CARD_W'(idx_q);
          value_d     = card_value(idx_q);
          valid_d     = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          idx_d = next_rank(idx_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= RANK_ACE;
      remaining_q <= FULL_REM;
      card_q      <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      card_q      <= card_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // Per-rank counters: refill on shuffle, decrement only on a successful probe.
  always_ff @(posedge clk_i) begin
    if (!rst_i || refill_c) begin
      for (int unsigned r = 0; r < NUM_RANKS; r++) count_q[r] <= FULL_CNT;
    end else if (take_c) begin
      for (int unsigned r = 0; r < NUM_RANKS; r++) begin
        if (idx_q == RANK_W'(r + 1)) count_q[r] <= count_q[r] - CNT_W'(1);
      end
    end
  end

  assign card_to_send_o = card_q;
  assign card_value_o   = value_q;
  assign card_valid_o   = valid_q;
  assign busy_o         = busy_q;
  assign remaining_o    = remaining_q;
  assign empty_err_o    = err_q;

endmodule
